// File: rtl/amns_host_bridge.sv
// Host-side bridge around the AMNS multiplier: streams operands into the shared
// BRAM, kicks the multiplier, then drains the result region through a 2-deep FIFO.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | one cycle after reset release, before accepting operands
// ST_LOAD  | s_ready_o high; each input word is written at wr_cnt
// ST_START | one-cycle start pulse to the multiplier
// ST_WAIT  | waiting for amns_done_i, BRAM port idle
// ST_DRAIN | reading result words into the FIFO and streaming them out
module amns_host_bridge #(
   parameter int WORD_WIDTH = 17,
   parameter int N          = 5,
   parameter int S          = 4,
   parameter int IN_WORDS   = 3*N*S + N,
   parameter int RES_BASE   = 3*N*S + N,
   parameter int OUT_WORDS  = N*S,
   parameter int ADDR_W     = $clog2(4*N*S + N) + 1
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic [WORD_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [WORD_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  m_last_o,
   output logic                  amns_start_o,
   input  logic                  amns_done_i,
   output logic                  bram_en_o,
   output logic                  bram_we_o,
   output logic [ADDR_W-1:0]     bram_addr_o,
   output logic [WORD_WIDTH-1:0] bram_din_o,
   input  logic [WORD_WIDTH-1:0] bram_dout_i,
   output logic                  busy_o
);

   localparam int WR_W = $clog2(IN_WORDS);
   localparam int RD_W = $clog2(OUT_WORDS) + 1;
   localparam logic [WR_W-1:0]   WR_LAST  = WR_W'(IN_WORDS - 1);
   localparam logic [RD_W-1:0]   RD_LAST  = RD_W'(OUT_WORDS - 1);
   localparam logic [RD_W-1:0]   RD_END   = RD_W'(OUT_WORDS);
   localparam logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(RES_BASE);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [WR_W-1:0]       wr_cnt;
   logic [RD_W-1:0]       rd_cnt;
   logic                  inflight;
   logic                  inflight_last;
   logic [WORD_WIDTH-1:0] fifo_data [2];
   logic [1:0]            fifo_last;
   logic                  fifo_wr_ptr;
   logic                  fifo_rd_ptr;
   logic [1:0]            fifo_cnt;

   logic       fifo_valid;
   logic       head_last;
   logic       s_hs;
   logic       m_hs;
   logic       rd_issue;
   logic [2:0] occupancy;

   assign fifo_valid = (fifo_cnt != 2'd0);
   assign head_last  = fifo_valid & fifo_last[fifo_rd_ptr];
   assign s_hs       = (state == ST_LOAD) & s_valid_i;
   assign m_hs       = fifo_valid & m_ready_i;
   assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight};
   // A word leaving the FIFO this cycle frees a slot, which keeps the drain at 1 word/cycle.
   assign rd_issue   = (state == ST_DRAIN) && (rd_cnt < RD_END) &&
                       (occupancy < (3'd2 + {2'b00, m_hs}));

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_LOAD;
         ST_LOAD:  if (s_hs && (wr_cnt == WR_LAST)) state_nxt = ST_START;
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT:  if (amns_done_i) state_nxt = ST_DRAIN;
         ST_DRAIN: if (m_hs && head_last) state_nxt = ST_LOAD;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready_o    = (state == ST_LOAD);
      busy_o       = (state != ST_LOAD);
      amns_start_o = (state == ST_START);
      m_valid_o    = fifo_valid;
      m_data_o     = fifo_data[fifo_rd_ptr];
      m_last_o     = head_last;
      bram_en_o    = 1'b0;
      bram_we_o    = 1'b0;
      bram_addr_o  = '0;
      bram_din_o   = '0;
      if (s_hs) begin
         bram_en_o   = 1'b1;
         bram_we_o   = 1'b1;
         bram_addr_o = ADDR_W'(wr_cnt);
         bram_din_o  = s_data_i;
      end else if (rd_issue) begin
         bram_en_o   = 1'b1;
         bram_addr_o = RES_ADDR + ADDR_W'(rd_cnt);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_last     <= 2'b00;
         fifo_wr_ptr   <= 1'b0;
         fifo_rd_ptr   <= 1'b0;
         fifo_cnt      <= 2'd0;
      end else begin
         if (s_hs) begin
            wr_cnt <= (wr_cnt == WR_LAST) ? '0 : wr_cnt + WR_W'(1);
         end
         if (m_hs && head_last) begin
            rd_cnt <= '0;
         end else if (rd_issue) begin
            rd_cnt <= rd_cnt + RD_W'(1);
         end
         // BRAM read data shows up the cycle after the read, tagged with its last flag.
         inflight      <= rd_issue;
         inflight_last <= rd_issue && (rd_cnt == RD_LAST);
         if (inflight) begin
            fifo_data[fifo_wr_ptr] <= bram_dout_i;
            fifo_last[fifo_wr_ptr] <= inflight_last;
            fifo_wr_ptr            <= ~fifo_wr_ptr;
         end
         if (m_hs) begin
            fifo_rd_ptr <= ~fifo_rd_ptr;
         end
         fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, m_hs};
      end
   end

endmodule
